// File: rtl/hazard_fwd_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_fwd_unit_if : ID-stage hazard/forwarding signal bundle              |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface hazard_fwd_unit_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_wr_en;
  logic [4:0] id_wr_addr;
  logic       id_is_load;
  logic       id_is_muldiv;
  logic       id_reads_hilo;
  logic       flush;
  logic       mem_wait;
  logic [1:0] fwd_rs;
  logic [1:0] fwd_rt;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       md_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
           id_is_load, id_is_muldiv, id_reads_hilo, flush, mem_wait,
    input  fwd_rs, fwd_rt, stall_if, stall_id, bubble_ex, md_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
           id_is_load, id_is_muldiv, id_reads_hilo, flush, mem_wait,
    output fwd_rs, fwd_rt, stall_if, stall_id, bubble_ex, md_busy
  );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_fwd_unit : ID-stage scoreboard, forward selects, load-use/md stalls |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module hazard_fwd_unit #(
  parameter int MD_LAT = 32
) (
  input wire clk,
  input wire rst,
  hazard_fwd_unit_if.slave hz
);

  localparam logic [5:0] C_MD_LOAD = 6'(MD_LAT);

  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [4:0] addr;
    logic       is_load;
  } slot_t;

  slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] fwd_rs_q, fwd_rs_d, fwd_rt_q, fwd_rt_d;
  logic [5:0] md_cnt_q, md_cnt_d;

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic load_use, md_stall, hazard, id_adv;
  logic stall_c, bubble_c;
  logic unused_wb;

  function automatic logic slot_hit(slot_t s, logic [4:0] src, logic use_src);
    return s.valid && s.wr_en && (s.addr == src) && (src != 5'd0) && use_src;
  endfunction

  // WB producers reach EX through register-file write-through, so they select 2'b00.
  function automatic logic [1:0] fwd_sel(logic ex_hit, logic mem_hit);
    if (ex_hit)       return 2'b10;
    else if (mem_hit) return 2'b01;
    else              return 2'b00;
  endfunction

  always_comb begin
    ex_hit_rs  = slot_hit(ex_q,  hz.id_rs, hz.id_use_rs);
    ex_hit_rt  = slot_hit(ex_q,  hz.id_rt, hz.id_use_rt);
    mem_hit_rs = slot_hit(mem_q, hz.id_rs, hz.id_use_rs);
    mem_hit_rt = slot_hit(mem_q, hz.id_rt, hz.id_use_rt);

    load_use = hz.id_valid && ex_q.is_load && (ex_hit_rs || ex_hit_rt);
    // Release HI/LO consumers once one cycle remains: they reach EX as the counter hits 0.
    md_stall = hz.id_valid && (md_cnt_q > 6'd1) && (hz.id_reads_hilo || hz.id_is_muldiv);
    hazard   = load_use || md_stall;
    id_adv   = hz.id_valid && !hz.flush && !hazard;

    if (hz.mem_wait) begin
      stall_c  = 1'b1;
      bubble_c = 1'b0;
    end else if (hz.flush) begin
      stall_c  = 1'b0;
      bubble_c = 1'b1;
    end else begin
      stall_c  = hazard;
      bubble_c = hazard;
    end

    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    fwd_rs_d = fwd_rs_q;
    fwd_rt_d = fwd_rt_q;
    md_cnt_d = md_cnt_q;

    if (!hz.mem_wait) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (id_adv) begin
        ex_d     = '{valid: 1'b1, wr_en: hz.id_wr_en, addr: hz.id_wr_addr,
                     is_load: hz.id_is_load};
        fwd_rs_d = fwd_sel(ex_hit_rs, mem_hit_rs);
        fwd_rt_d = fwd_sel(ex_hit_rt, mem_hit_rt);
      end else begin
        ex_d     = '0;
        fwd_rs_d = 2'b00;
        fwd_rt_d = 2'b00;
      end

      if (id_adv && hz.id_is_muldiv)
        md_cnt_d = C_MD_LOAD;
      else if (md_cnt_q != 6'd0)
        md_cnt_d = md_cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      fwd_rs_q <= 2'b00;
      fwd_rt_q <= 2'b00;
      md_cnt_q <= 6'd0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      fwd_rs_q <= fwd_rs_d;
      fwd_rt_q <= fwd_rt_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign unused_wb    = ^wb_q;

  assign hz.fwd_rs    = fwd_rs_q;
  assign hz.fwd_rt    = fwd_rt_q;
  assign hz.stall_if  = stall_c;
  assign hz.stall_id  = stall_c;
  assign hz.bubble_ex = bubble_c;
  assign hz.md_busy   = (md_cnt_q != 6'd0);

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_fwd_unit : directed self-checking bench for hazard_fwd_unit      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  hazard_fwd_unit_if hz ();

  hazard_fwd_unit #(.MD_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [4:0] wa, input logic ld, input logic md,
                        input logic hl);
    hz.id_valid      = v;
    hz.id_rs         = rs;
    hz.id_rt         = rt;
    hz.id_use_rs     = urs;
    hz.id_use_rt     = urt;
    hz.id_wr_en      = we;
    hz.id_wr_addr    = wa;
    hz.id_is_load    = ld;
    hz.id_is_muldiv  = md;
    hz.id_reads_hilo = hl;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  task automatic test_reset;
    hz.flush = 0; hz.mem_wait = 0;
    idle(0);
    rst = 1;
    repeat (2) cyc();
    rst = 0;
    #1;
    n_vec++; if (hz.fwd_rs !== 2'b00) begin n_err++; $display("FAIL reset_fwd_rs got=%b exp=00", hz.fwd_rs); end
    n_vec++; if (hz.fwd_rt !== 2'b00) begin n_err++; $display("FAIL reset_fwd_rt got=%b exp=00", hz.fwd_rt); end
    n_vec++; if ({hz.stall_if, hz.stall_id, hz.bubble_ex, hz.md_busy} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctl got=%b exp=0000", {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.md_busy}); end
  endtask

  task automatic test_back_to_back;
    set_id(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);           // addu $3,$1,$2
    cyc();
    set_id(1, 3, 3, 1, 1, 1, 4, 0, 0, 0);           // addu $4,$3,$3
    #1;
    n_vec++; if (hz.stall_if !== 1'b0) begin n_err++; $display("FAIL b2b_stall got=%b exp=0", hz.stall_if); end
    cyc();
    n_vec++; if (hz.fwd_rs !== 2'b10) begin n_err++; $display("FAIL b2b_fwd_rs got=%b exp=10", hz.fwd_rs); end
    n_vec++; if (hz.fwd_rt !== 2'b10) begin n_err++; $display("FAIL b2b_fwd_rt got=%b exp=10", hz.fwd_rt); end
    idle(3);
  endtask

  task automatic test_mem_fwd;
    set_id(1, 1, 2, 1, 1, 1, 5, 0, 0, 0);           // producer $5
    cyc();
    set_id(1, 1, 2, 1, 1, 1, 6, 0, 0, 0);           // independent
    cyc();
    set_id(1, 5, 2, 1, 1, 1, 10, 0, 0, 0);          // consumer of $5
    cyc();
    n_vec++; if (hz.fwd_rs !== 2'b01) begin n_err++; $display("FAIL memfwd_rs got=%b exp=01", hz.fwd_rs); end
    n_vec++; if (hz.fwd_rt !== 2'b00) begin n_err++; $display("FAIL memfwd_rt got=%b exp=00", hz.fwd_rt); end
    idle(3);
    set_id(1, 1, 2, 1, 1, 1, 0, 0, 0, 0);           // producer $0
    cyc();
    set_id(1, 1, 2, 1, 1, 1, 6, 0, 0, 0);
    cyc();
    set_id(1, 0, 2, 1, 1, 1, 10, 0, 0, 0);
    cyc();
    n_vec++; if (hz.fwd_rs !== 2'b00) begin n_err++; $display("FAIL zero_reg_rs got=%b exp=00", hz.fwd_rs); end
    idle(3);
  endtask

  task automatic test_load_use;
    set_id(1, 1, 0, 1, 0, 1, 7, 1, 0, 0);           // lw $7,0($1)
    cyc();
    set_id(1, 7, 2, 1, 1, 1, 8, 0, 0, 0);           // addu $8,$7,$2
    #1;
    n_vec++; if ({hz.stall_if, hz.stall_id, hz.bubble_ex} !== 3'b111) begin
      n_err++; $display("FAIL lu_stall got=%b exp=111", {hz.stall_if, hz.stall_id, hz.bubble_ex}); end
    cyc();
    n_vec++; if (hz.fwd_rs !== 2'b00) begin n_err++; $display("FAIL lu_bubble_fwd got=%b exp=00", hz.fwd_rs); end
    n_vec++; if ({hz.stall_if, hz.stall_id, hz.bubble_ex} !== 3'b000) begin
      n_err++; $display("FAIL lu_release got=%b exp=000", {hz.stall_if, hz.stall_id, hz.bubble_ex}); end
    cyc();
    n_vec++; if (hz.fwd_rs !== 2'b01) begin n_err++; $display("FAIL lu_fwd_rs got=%b exp=01", hz.fwd_rs); end
    n_vec++; if (hz.fwd_rt !== 2'b00) begin n_err++; $display("FAIL lu_fwd_rt got=%b exp=00", hz.fwd_rt); end
    idle(3);
  endtask

  task automatic test_ex_priority;
    set_id(1, 1, 2, 1, 1, 1, 9, 0, 0, 0);
    cyc();
    set_id(1, 1, 2, 1, 1, 1, 9, 0, 0, 0);
    cyc();
    set_id(1, 1, 9, 0, 1, 1, 12, 0, 0, 0);          // reads $9 in rt only
    cyc();
    n_vec++; if (hz.fwd_rt !== 2'b10) begin n_err++; $display("FAIL prio_fwd_rt got=%b exp=10", hz.fwd_rt); end
    n_vec++; if (hz.fwd_rs !== 2'b00) begin n_err++; $display("FAIL prio_fwd_rs got=%b exp=00", hz.fwd_rs); end
    idle(3);
  endtask

  task automatic test_muldiv;
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);           // mult $1,$2
    cyc();
    set_id(1, 0, 0, 0, 0, 1, 13, 0, 0, 1);          // mflo $13
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++; if (hz.md_busy !== 1'b1) begin n_err++; $display("FAIL md_busy[%0d] got=%b exp=1", k, hz.md_busy); end
      n_vec++; if (hz.stall_if !== (k < 3)) begin
        n_err++; $display("FAIL md_stall[%0d] got=%b exp=%b", k, hz.stall_if, (k < 3)); end
      cyc();
    end
    n_vec++; if (hz.md_busy !== 1'b0) begin n_err++; $display("FAIL md_done got=%b exp=0", hz.md_busy); end
    n_vec++; if ({hz.fwd_rs, hz.fwd_rt} !== 4'b0000) begin
      n_err++; $display("FAIL md_fwd got=%b exp=0000", {hz.fwd_rs, hz.fwd_rt}); end
    idle(3);
  endtask

  task automatic test_flush;
    set_id(1, 1, 0, 1, 0, 1, 7, 1, 0, 0);           // lw $7
    cyc();
    set_id(1, 7, 2, 1, 1, 1, 8, 0, 0, 0);
    hz.flush = 1;
    #1;
    n_vec++; if ({hz.stall_if, hz.stall_id, hz.bubble_ex} !== 3'b001) begin
      n_err++; $display("FAIL flush_lu got=%b exp=001", {hz.stall_if, hz.stall_id, hz.bubble_ex}); end
    cyc();
    n_vec++; if (hz.fwd_rs !== 2'b00) begin n_err++; $display("FAIL flush_fwd got=%b exp=00", hz.fwd_rs); end
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);           // flushed mult
    cyc();
    hz.flush = 0;
    #1;
    n_vec++; if (hz.md_busy !== 1'b0) begin n_err++; $display("FAIL flush_md got=%b exp=0", hz.md_busy); end
    idle(3);
  endtask

  task automatic test_mem_wait;
    set_id(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);           // P1 -> $3
    cyc();
    set_id(1, 3, 1, 1, 1, 1, 4, 0, 0, 0);           // C1 reads $3 -> $4
    cyc();
    set_id(1, 3, 2, 1, 1, 1, 11, 0, 0, 0);          // C2 reads $3
    hz.mem_wait = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) hz.flush = 1;
      #1;
      n_vec++; if ({hz.stall_if, hz.stall_id, hz.bubble_ex} !== 3'b110) begin
        n_err++; $display("FAIL mw_ctl[%0d] got=%b exp=110", k, {hz.stall_if, hz.stall_id, hz.bubble_ex}); end
      hz.flush = 0;
      cyc();
      n_vec++; if (hz.fwd_rs !== 2'b10) begin n_err++; $display("FAIL mw_hold[%0d] got=%b exp=10", k, hz.fwd_rs); end
    end
    hz.mem_wait = 0;
    cyc();
    n_vec++; if (hz.fwd_rs !== 2'b01) begin n_err++; $display("FAIL mw_resume got=%b exp=01", hz.fwd_rs); end
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);           // mult, then freeze counter
    cyc();
    idle(0);
    hz.mem_wait = 1;
    repeat (6) cyc();
    n_vec++; if (hz.md_busy !== 1'b1) begin n_err++; $display("FAIL mw_md_hold got=%b exp=1", hz.md_busy); end
    hz.mem_wait = 0;
    idle(5);
    n_vec++; if (hz.md_busy !== 1'b0) begin n_err++; $display("FAIL mw_md_drain got=%b exp=0", hz.md_busy); end
  endtask

  task automatic test_reset_mid_mult;
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);
    cyc();
    set_id(1, 0, 0, 0, 0, 1, 13, 0, 0, 1);          // mflo, stalled
    #1;
    n_vec++; if (hz.stall_if !== 1'b1) begin n_err++; $display("FAIL rm_pre_stall got=%b exp=1", hz.stall_if); end
    rst = 1;
    cyc();
    rst = 0;
    #1;
    n_vec++; if (hz.md_busy !== 1'b0) begin n_err++; $display("FAIL rm_md_busy got=%b exp=0", hz.md_busy); end
    n_vec++; if (hz.stall_if !== 1'b0) begin n_err++; $display("FAIL rm_stall got=%b exp=0", hz.stall_if); end
    idle(2);
  endtask

  initial begin
    hz.flush = 0;
    hz.mem_wait = 0;
    idle(0);
    test_reset();
    test_back_to_back();
    test_mem_fwd();
    test_load_use();
    test_ex_priority();
    test_muldiv();
    test_flush();
    test_mem_wait();
    test_reset_mid_mult();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
